// File: rtl/amp_seq_pkg.sv
// amp_seq shared types: state encoding (also used by LED/debug logic)
// and default timing constants for a 50 MHz system clock.
package amp_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WARM   = 3'd1,
        ST_UNMUTE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAULT  = 3'd4,
        ST_RECOV  = 3'd5,
        ST_LOCK   = 3'd6
    } amp_state_t;

    localparam int PWRUP_CYC_DEF = 250000;
    localparam int RETRY_CYC_DEF = 2500000;
    localparam int FLT_DEB_DEF   = 16;
    localparam int MAX_RETRY_DEF = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/flt_sync_deb.sv
// Amp fault input: 2-flop synchronizer plus saturating low-level debounce.
// flt_det stays high while the debounce count sits at FLT_DEB.
module flt_sync_deb
    import amp_seq_pkg::*;
#(
    parameter int FLT_DEB = FLT_DEB_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flt_n,
    output logic flt_s,
    output logic flt_det
);

    localparam int CW = $clog2(FLT_DEB + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FLT_DEB);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d  = flt_n;
        s2_d  = s1_q;
        cnt_d = cnt_q;
        if (s2_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= 1'b1;
            s2_q  <= 1'b1;
            cnt_q <= '0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            cnt_q <= cnt_d;
        end
    end

    assign flt_s   = s2_q;
    assign flt_det = (cnt_q == CNT_MAX);

endmodule

// File: rtl/amp_seq.sv
// Class-D amp power/fault sequencer: warm-up, sample-aligned unmute, retry.
// Define AMP_SEQ_LOCKOUT_EN to enable the LOCK state after MAX_RETRY faults.
module amp_seq
    import amp_seq_pkg::*;
#(
    parameter int PWRUP_CYC = PWRUP_CYC_DEF,
    parameter int RETRY_CYC = RETRY_CYC_DEF,
    parameter int FLT_DEB   = FLT_DEB_DEF,
    parameter int MAX_RETRY = MAX_RETRY_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Flt_n,
    input  logic       seq_low,
    input  logic       vld,
    input  logic       clr_lock,
    output logic       sht_dwn,
    output logic       mute,
    output logic [2:0] state,
    output logic [2:0] retry_cnt,
    output logic       lockout
);

    localparam int TW = $clog2(max_int(PWRUP_CYC, RETRY_CYC)) + 1;
    localparam logic [TW-1:0] WARM_END  = TW'(PWRUP_CYC - 1);
    localparam logic [TW-1:0] RETRY_END = TW'(RETRY_CYC - 1);
    localparam logic [TW-1:0] RUN_SAT   = TW'(RETRY_CYC);

    amp_state_t    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    retry_q, retry_d;
    logic          sht_dwn_q, sht_dwn_d;
    logic          mute_q, mute_d;
    logic          lockout_q, lockout_d;
    logic          flt_s, flt_det;

    flt_sync_deb #(.FLT_DEB(FLT_DEB)) u_flt (
        .clk     (clk),
        .rst_n   (rst_n),
        .flt_n   (Flt_n),
        .flt_s   (flt_s),
        .flt_det (flt_det)
    );

`ifdef AMP_SEQ_LOCKOUT_EN
    localparam logic [2:0] MAX_R = 3'(MAX_RETRY);
`else
    logic unused_cfg;
    assign unused_cfg = clr_lock ^ (MAX_RETRY > 0);
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (seq_low) state_d = ST_WARM;
            // a vld on the warm-up expiry edge unmutes immediately
            ST_WARM: begin
                if (flt_det) state_d = ST_FAULT;
                else if (timer_q == WARM_END)
                    state_d = vld ? ST_RUN : ST_UNMUTE;
            end
            ST_UNMUTE: begin
                if (flt_det) state_d = ST_FAULT;
                else if (vld) state_d = ST_RUN;
            end
            ST_RUN:    if (flt_det) state_d = ST_FAULT;
            ST_FAULT:  state_d = ST_RECOV;
            ST_RECOV: begin
                if (flt_s && timer_q == RETRY_END) begin
`ifdef AMP_SEQ_LOCKOUT_EN
                    state_d = (retry_q >= MAX_R) ? ST_LOCK : ST_WARM;
`else
                    state_d = ST_WARM;
`endif
                end
            end
`ifdef AMP_SEQ_LOCKOUT_EN
            ST_LOCK:   if (clr_lock) state_d = ST_IDLE;
`else
            ST_LOCK:   state_d = ST_IDLE;
`endif
            default:   state_d = ST_IDLE;
        endcase
    end

    // shared timer restarts on every state change
    always_comb begin
        timer_d = '0;
        if (state_d == state_q) begin
            if (state_q == ST_WARM) begin
                timer_d = timer_q + TW'(1);
            end else if (state_q == ST_RUN) begin
                timer_d = (timer_q == RUN_SAT) ? timer_q : timer_q + TW'(1);
            end else if (state_q == ST_RECOV) begin
                timer_d = flt_s ? timer_q + TW'(1) : '0;
            end
        end
    end

    always_comb begin
        retry_d = retry_q;
        if (state_d == ST_FAULT && state_q != ST_FAULT) begin
            if (retry_q != 3'd7) retry_d = retry_q + 3'd1;
        end else if (state_q == ST_RUN && timer_q == RETRY_END) begin
            retry_d = '0;
        end else if (state_q == ST_LOCK && state_d == ST_IDLE) begin
            retry_d = '0;
        end
    end

    always_comb begin
        sht_dwn_d = !(state_d == ST_UNMUTE || state_d == ST_RUN);
        mute_d    = (state_d != ST_RUN);
`ifdef AMP_SEQ_LOCKOUT_EN
        lockout_d = (state_d == ST_LOCK);
`else
        lockout_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            retry_q   <= '0;
            sht_dwn_q <= 1'b1;
            mute_q    <= 1'b1;
            lockout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            sht_dwn_q <= sht_dwn_d;
            mute_q    <= mute_d;
            lockout_q <= lockout_d;
        end
    end

    assign sht_dwn   = sht_dwn_q;
    assign mute      = mute_q;
    assign state     = state_q;
    assign retry_cnt = retry_q;
    assign lockout   = lockout_q;

endmodule

// File: tb/tb_amp_seq.sv
// Directed bench for amp_seq with short timing parameters.
// Lock checks apply when AMP_SEQ_LOCKOUT_EN is defined.
module tb_amp_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flt_n;
    logic       seq_low;
    logic       vld;
    logic       clr_lock;
    logic       sht_dwn;
    logic       mute;
    logic [2:0] state;
    logic [2:0] retry_cnt;
    logic       lockout;

    int n_cmp = 0;
    int n_bad = 0;

    localparam int S_IDLE = 0, S_WARM = 1, S_UNMUTE = 2, S_RUN = 3;
    localparam int S_FAULT = 4, S_RECOV = 5, S_LOCK = 6;

    amp_seq #(
        .PWRUP_CYC (100),
        .RETRY_CYC (200),
        .FLT_DEB   (4),
        .MAX_RETRY (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Flt_n     (flt_n),
        .seq_low   (seq_low),
        .vld       (vld),
        .clr_lock  (clr_lock),
        .sht_dwn   (sht_dwn),
        .mute      (mute),
        .state     (state),
        .retry_cnt (retry_cnt),
        .lockout   (lockout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic sl;
        logic v;
        logic fn;
        logic cl;
        int   st;
        int   sht;
        int   mu;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    task automatic step(input logic sl, input logic v,
                        input logic fn, input logic cl);
        seq_low  = sl;
        vld      = v;
        flt_n    = fn;
        clr_lock = cl;
        @(posedge clk);
        #1;
    endtask

    // Flt_n low for 6 samples: detection lands on the 7th edge
    task automatic inject_fault(input int pre, input int exp_retry);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_fault_state", int'(state), pre);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("fault_state", int'(state), S_FAULT);
        chk("fault_sht", int'(sht_dwn), 1);
        chk("fault_mute", int'(mute), 1);
        chk("fault_retry", int'(retry_cnt), exp_retry);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("recov_state", int'(state), S_RECOV);
    endtask

    task automatic recov_wait(input int target);
        int n;
        n = 0;
        do begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            n++;
        end while (int'(state) == S_RECOV && n < 400);
        chk("recov_cycles", n, 200);
        chk("recov_exit", int'(state), target);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        int bad;

        vt[0] = '{1'b0, 1'b1, 1'b1, 1'b1, S_IDLE, 1, 1};
        vt[1] = '{1'b0, 1'b0, 1'b0, 1'b0, S_IDLE, 1, 1};
        vt[2] = '{1'b0, 1'b0, 1'b1, 1'b0, S_IDLE, 1, 1};
        vt[3] = '{1'b1, 1'b0, 1'b1, 1'b0, S_WARM, 1, 1};
        vt[4] = '{1'b0, 1'b1, 1'b1, 1'b0, S_WARM, 1, 1};

        rst_n = 1'b0;
        flt_n = 1'b1;
        seq_low = 1'b0;
        vld = 1'b0;
        clr_lock = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", int'(state), S_IDLE);
        chk("rst_sht", int'(sht_dwn), 1);
        chk("rst_mute", int'(mute), 1);
        chk("rst_retry", int'(retry_cnt), 0);
        chk("rst_lockout", int'(lockout), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            step(vt[i].sl, vt[i].v, vt[i].fn, vt[i].cl);
            chk($sformatf("vec%0d_state", i), int'(state), vt[i].st);
            chk($sformatf("vec%0d_sht", i), int'(sht_dwn), vt[i].sht);
            chk($sformatf("vec%0d_mute", i), int'(mute), vt[i].mu);
        end

        for (int j = 2; j <= 99; j++) begin
            step(1'b0, (j % 20) == 0, 1'b1, 1'b0);
        end
        chk("warm99_state", int'(state), S_WARM);
        chk("warm99_sht", int'(sht_dwn), 1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("warm100_state", int'(state), S_UNMUTE);
        chk("warm100_sht", int'(sht_dwn), 0);
        chk("warm100_mute", int'(mute), 1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("unmute_hold", int'(state), S_UNMUTE);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("run_state", int'(state), S_RUN);
        chk("run_mute", int'(mute), 0);
        chk("run_sht", int'(sht_dwn), 0);

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("glitch_state", int'(state), S_RUN);
        chk("glitch_sht", int'(sht_dwn), 0);

        inject_fault(S_RUN, 1);

        found = 0;
        for (int j = 1; j <= 400; j++) begin
            step(1'b0, 1'b0, (j == 150) ? 1'b0 : 1'b1, 1'b0);
            if (j == 200) chk("recov_restart_200", int'(state), S_RECOV);
            if (int'(state) != S_RECOV) begin
                found = j;
                break;
            end
        end
        chk("recov_restart_exit", found, 352);
        chk("recov_restart_warm", int'(state), S_WARM);

        for (int j = 1; j <= 100; j++) begin
            step(1'b0, j == 100, 1'b1, 1'b0);
            if (j == 99) chk("warm2_99", int'(state), S_WARM);
        end
        chk("same_edge_vld_state", int'(state), S_RUN);
        chk("same_edge_vld_sht", int'(sht_dwn), 0);
        chk("same_edge_vld_mute", int'(mute), 0);

        for (int j = 1; j <= 200; j++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            if (j == 199) chk("retry_before_clr", int'(retry_cnt), 1);
        end
        chk("retry_run_clr", int'(retry_cnt), 0);
        chk("retry_run_state", int'(state), S_RUN);

        inject_fault(S_RUN, 1);
        recov_wait(S_WARM);
        inject_fault(S_WARM, 2);

`ifdef AMP_SEQ_LOCKOUT_EN
        recov_wait(S_LOCK);
        chk("lock_lockout", int'(lockout), 1);
        chk("lock_sht", int'(sht_dwn), 1);
        chk("lock_mute", int'(mute), 1);
        bad = 0;
        for (int i = 0; i < 10000; i++) begin
            step(1'b1, (i % 20) == 0, 1'b1, 1'b0);
            if (int'(state) != S_LOCK || sht_dwn != 1'b1 || mute != 1'b1)
                bad++;
        end
        chk("lock_hold_bad", bad, 0);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("clr_state", int'(state), S_IDLE);
        chk("clr_retry", int'(retry_cnt), 0);
        chk("clr_lockout", int'(lockout), 0);
        chk("clr_sht", int'(sht_dwn), 1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("relaunch_warm", int'(state), S_WARM);
`else
        recov_wait(S_WARM);
        chk("nolock_lockout", int'(lockout), 0);
        for (int f = 3; f <= 8; f++) begin
            inject_fault(S_WARM, (f > 7) ? 7 : f);
            recov_wait(S_WARM);
            if (f == 5) chk("nolock_retry5", int'(retry_cnt), 5);
        end
        chk("nolock_sat", int'(retry_cnt), 7);
        chk("nolock_lockout_end", int'(lockout), 0);
`endif

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_warm_state", int'(state), S_IDLE);
        chk("rst_warm_sht", int'(sht_dwn), 1);
        chk("rst_warm_mute", int'(mute), 1);
        chk("rst_warm_retry", int'(retry_cnt), 0);
        chk("rst_warm_lockout", int'(lockout), 0);
        @(negedge clk);
        rst_n = 1'b1;

        step(1'b1, 1'b0, 1'b1, 1'b0);
        for (int j = 1; j <= 102; j++) begin
            step(1'b0, j == 102, 1'b1, 1'b0);
            if (j == 100) chk("again_unmute", int'(state), S_UNMUTE);
        end
        chk("again_run", int'(state), S_RUN);
        chk("again_sht", int'(sht_dwn), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_run_sht", int'(sht_dwn), 1);
        chk("rst_run_mute", int'(mute), 1);
        chk("rst_run_state", int'(state), S_IDLE);
        @(negedge clk);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/amp_seq.md
# amp_seq

Amplifier power/fault sequencer that owns the class-D amp `sht_dwn` line and a `mute` request to the speaker driver. It replaces the ad-hoc shutdown timer at the equalizer top level. It holds the amp off until the EQ low-frequency queues are primed, then enforces a warm-up delay and unmutes on a sample boundary. On a debounced amp fault it shuts down, retries after a cool-down, and locks out after repeated faults.

## Interface
- `PWRUP_CYC`, 250000: clocks `sht_dwn` stays high in WARM (5 ms at 50 MHz).
- `RETRY_CYC`, 2500000: fault-free clocks required in RECOV before retry; also RUN time that clears the retry count.
- `FLT_DEB`, 16: consecutive synchronized-low clocks of `Flt_n` that constitute a fault (≥1).
- `MAX_RETRY`, 3: faults tolerated before LOCK (1..7).
- `clk`  in  1  50 MHz system clock.
- `rst_n`  in  1  asynchronous active-low reset (already synchronized at top level).
- `Flt_n`  in  1  amp fault, active low, asynchronous to `clk`.
- `seq_low`  in  1  EQ low-frequency queues full; level.
- `vld`  in  1  one-clock new-sample strobe from I2S receiver.
- `clr_lock`  in  1  one-clock pulse; exits LOCK.
- `sht_dwn`  out  1  amp shutdown, high = amp off.
- `mute`  out  1  speaker driver mute request, high = drive mid-scale.
- `state`  out  3  current state encoding (debug/LED).
- `retry_cnt`  out  3  faults since last clear.
- `lockout`  out  1  high in LOCK.

## Operation
- States: IDLE, WARM, UNMUTE, RUN, FAULT, RECOV, LOCK. Encoding: IDLE=0 through LOCK=6, in that order.
- Outputs per state:
  - `sht_dwn`=1 in IDLE, WARM, FAULT, RECOV, LOCK; 0 in UNMUTE and RUN.
  - `mute`=0 only in RUN.
  - `lockout`=1 only in LOCK.
- Transitions:
  - IDLE→WARM when `seq_low`=1.
  - WARM→UNMUTE after exactly PWRUP_CYC clocks in WARM; `seq_low` is ignored once WARM is entered.
  - UNMUTE→RUN on the first clock with `vld`=1.
  - RUN: after RETRY_CYC consecutive clocks in RUN, `retry_cnt`←0; the count does not re-clear until the next fault.
  - `flt_det` in WARM, UNMUTE or RUN → FAULT; `flt_det` has priority over any other transition that clock.
  - FAULT→RECOV unconditionally after 1 clock; `retry_cnt` increments (saturating at 7) on FAULT entry.
  - RECOV→WARM after RETRY_CYC consecutive clocks with synchronized `Flt_n`=1; any low sample restarts the count.
  - RECOV→LOCK instead if `retry_cnt` ≥ MAX_RETRY.
  - LOCK→IDLE on `clr_lock`; `retry_cnt`←0. `clr_lock` is ignored in all other states.
- Fault detect: `Flt_n` is synchronized by 2 flops. The debounce counter increments while the synchronized value is 0, clears on 1, and saturates at FLT_DEB. `flt_det`=1 while count==FLT_DEB. Faults in IDLE, FAULT, RECOV and LOCK are not counted.
- One shared timer, width $clog2(max(PWRUP_CYC,RETRY_CYC))+1. It clears on every state change.

## Timing
- Reset values: `sht_dwn`=1, `mute`=1, `state`=IDLE, `retry_cnt`=0, `lockout`=0, timer=0, debounce=0, sync flops=1.
- All outputs are registered, decoded from the next-state on the same edge the state register updates.
- Fault latency: `Flt_n` low sampled at edge k gives `sht_dwn`=1 and `mute`=1 at edge k+FLT_DEB+2.
- Unmute: `sht_dwn` falls at edge PWRUP_CYC after WARM entry. `mute` falls on the edge that samples the first `vld`=1 after that, including a `vld` on the same edge UNMUTE is entered.
- Reset asserted mid-operation: immediate return to reset values, no output glitch beyond the async transition.

## Configuration
- `AMP_SEQ_LOCKOUT_EN` defined: LOCK state, `MAX_RETRY` and `clr_lock` behave as above.
- Not defined: RECOV always proceeds to WARM, LOCK is unreachable, `lockout` is tied 0, `clr_lock` is unused, and `retry_cnt` still counts and saturates.

## Structure
- `amp_seq_pkg`: `amp_state_t` enum (3-bit, encodings above) and default parameter constants. The LED/debug logic imports it.
- Sub-module `flt_sync_deb`: 2-flop synchronizer plus debounce counter, parameter FLT_DEB, output `flt_det`.
- The FSM, timer and retry counter live in `amp_seq`.

## Test plan
Run with PWRUP_CYC=100, RETRY_CYC=200, FLT_DEB=4, MAX_RETRY=2, macro defined.
- Reset, `seq_low`=1 at cycle 10, `vld` every 20 clocks → `sht_dwn` falls exactly 100 clocks after WARM entry; `mute` falls on the next `vld`; state=RUN.
- In RUN, `Flt_n` low 3 clocks then high → no fault; low 4+ clocks → `sht_dwn`=1 at edge k+6, `retry_cnt`=1, state RECOV.
- In RECOV, `Flt_n` pulse low at clock 150 of 200 → timer restarts; WARM entered 200 clocks after the pulse ends.
- Second fault → LOCK, `lockout`=1, outputs stay shut down for 10k clocks; `clr_lock` pulse → IDLE, `retry_cnt`=0.
- One fault, then RUN for ≥200 clocks → `retry_cnt` clears to 0; `rst_n` asserted in WARM → IDLE, `sht_dwn`=1 immediately.
- Macro undefined: 5 consecutive faults → never LOCK, `retry_cnt`=5, `lockout`=0.
